lamp_conflict_monitor: RTL and testbench
========================================

// Module: lamp_conflict_monitor
// PURPOSE
//  Independent safety monitor that reads the five lamp drive lines produced by the pedestrian
//  crossing controller and checks them against the legal lamp patterns and phase order.
//  Latches a fault code on an illegal pattern, a road/pedestrian conflict, a stuck phase or an
//  out-of-order transition, and asserts safe_override for the board-level lamp cut-off.
// PARAMETERS
//  TIMER_SCALE      16000000  clock cycles per second
//  GLITCH_CYCLES    16        consecutive equal samples before a pattern is accepted (>=2)
//  CONFLICT_CYCLES  2         consecutive conflict samples before fault 2 (>=1)
//  STUCK_SECONDS    20        max dwell of any accepted pattern; STUCK_SECONDS*TIMER_SCALE < 2^30
// PORTS
//  pin3_clk_16mhz  in   1  system clock; one clock domain
//  reset           in   1  synchronous, active-high reset
//  lamp_green      in   1  road green line
//  lamp_yellow     in   1  road yellow line
//  lamp_red        in   1  road red line
//  lamp_ped_green  in   1  pedestrian green line
//  lamp_ped_red    in   1  pedestrian red line
//  fault_clear     in   1  operator clear; honoured only in FAULT
//  fault           out  1  latched fault flag
//  fault_code      out  3  0 none, 1 illegal, 2 conflict, 3 stuck, 4 bad transition
//  safe_override   out  1  equals fault; registered
//  in_sync         out  1  1 while monitor is locked to the phase sequence (RUN)
//  phase           out  3  tracked phase: 0 none,1 TEST,2 GREEN,3 YELLOW,4 RED_A,5 PED_GREEN,6 RED_B
// BEHAVIOUR
//  - Reset: all outputs 0, state INIT, synchronisers, counters, accepted pattern cleared to 0.
//  - Pattern P = {ped_red, ped_green, red, yellow, green}, taken after a 2-flop synchroniser.
//  - Debounce: P accepted when equal for GLITCH_CYCLES consecutive cycles; acceptance checks
//    act on the cycle after acceptance (total ~2+GLITCH_CYCLES+1 cycles from pin change).
//  - Legal: 11111 TEST, 10001 GREEN, 10010 YELLOW, 10100 RED, 01100 PED_GREEN; 00000 legal in INIT only.
//  - Conflict: synchronised P has ped_green & (green|yellow) and P != 11111, for CONFLICT_CYCLES
//    consecutive cycles -> fault 2. Not debounced otherwise; checked in INIT and RUN.
//  - Allowed accepted transitions: TEST->GREEN, GREEN->YELLOW, YELLOW->RED_A, RED_A->PED_GREEN,
//    PED_GREEN->RED_B, RED_B->GREEN. 10100 maps to RED_A after YELLOW, RED_B after PED_GREEN.
//  - Dwell timer (30 bit): reloads to 0 on every accepted change, increments otherwise, saturates;
//    reaching STUCK_SECONDS*TIMER_SCALE in INIT or RUN -> fault 3.
//  States:
//   INIT: 00000 tolerated; accepted 11111/10001/10010/01100 set phase and -> RUN, in_sync=1;
//     accepted 10100 stays INIT (ambiguous phase); any other accepted pattern -> fault 1.
//   RUN: accepted illegal pattern (incl 00000) -> fault 1; legal but not allowed transition -> fault 4;
//     re-accepting the same pattern is not a transition.
//   FAULT: fault=1, safe_override=1, in_sync=0, phase holds last value; further faults ignored
//     (first code kept). fault_clear=1 -> INIT next cycle, fault/code/override cleared, dwell reset.
//  - Simultaneous faults same cycle: priority 2 > 1 > 4 > 3. Fault outputs assert one cycle after detection.
//  - fault_clear outside FAULT has no effect. Reset mid-operation overrides everything, incl FAULT.
// TESTING (TIMER_SCALE=10, GLITCH_CYCLES=4, CONFLICT_CYCLES=2, STUCK_SECONDS=20)
//  1 Normal run: 00000,11111,10001,10010,10100,01100,10100,10001 each held 50 cycles -> fault=0,
//    in_sync=1 after TEST accepted, phase 1,2,3,4,5,6,2.
//  2 Conflict: in GREEN drive 11001 for 2 cycles -> fault=1, code=2; 1-cycle 11001 pulse -> no fault.
//  3 Bad order: GREEN then 10100 stable -> code=4; then 01000 stable -> code stays 4.
//  4 Stuck: hold 10001 for 201 cycles -> code=3 at dwell count 200; changing at 190 -> no fault.
//  5 Clear: in FAULT pulse fault_clear -> next cycle fault=0, code=0, in_sync=0; INIT with 10100
//    stays INIT, then 01100 -> RUN phase 5.
//  6 Reset mid-FAULT and mid-debounce -> all outputs 0 next cycle; 3-cycle glitch of 00110 -> ignored.

Source files
------------

// File: rtl/lamp_conflict_monitor.sv
// Lamp conflict monitor: watches the five lamp drive lines of the pedestrian
// crossing controller, tracks the phase sequence and latches the first fault
// (illegal pattern, road/pedestrian conflict, stuck phase, bad transition).
module lamp_conflict_monitor #(
    parameter int TIMER_SCALE     = 16000000,
    parameter int GLITCH_CYCLES   = 16,
    parameter int CONFLICT_CYCLES = 2,
    parameter int STUCK_SECONDS   = 20
) (
    input  logic       pin3_clk_16mhz,
    input  logic       reset,
    input  logic       lamp_green,
    input  logic       lamp_yellow,
    input  logic       lamp_red,
    input  logic       lamp_ped_green,
    input  logic       lamp_ped_red,
    input  logic       fault_clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       safe_override,
    output logic       in_sync,
    output logic [2:0] phase
);

    // Pattern bit order: {ped_red, ped_green, red, yellow, green}
    localparam logic [4:0] PAT_OFF    = 5'b00000;
    localparam logic [4:0] PAT_TEST   = 5'b11111;
    localparam logic [4:0] PAT_GREEN  = 5'b10001;
    localparam logic [4:0] PAT_YELLOW = 5'b10010;
    localparam logic [4:0] PAT_RED    = 5'b10100;
    localparam logic [4:0] PAT_PED    = 5'b01100;

    localparam logic [2:0] PH_NONE      = 3'd0;
    localparam logic [2:0] PH_TEST      = 3'd1;
    localparam logic [2:0] PH_GREEN     = 3'd2;
    localparam logic [2:0] PH_YELLOW    = 3'd3;
    localparam logic [2:0] PH_RED_A     = 3'd4;
    localparam logic [2:0] PH_PED_GREEN = 3'd5;
    localparam logic [2:0] PH_RED_B     = 3'd6;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_STUCK    = 3'd3;
    localparam logic [2:0] CODE_ORDER    = 3'd4;

    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam int CW = $clog2(CONFLICT_CYCLES + 1);
    localparam logic [29:0] STUCK_LIMIT = 30'(STUCK_SECONDS * TIMER_SCALE);
    localparam logic [29:0] DWELL_MAX   = '1;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

    state_t          state, state_d;
    logic [2:0]      code_d, phase_d;
    logic [4:0]      pins, sync1, sync2;
    logic [4:0]      cand, acc_pat;
    logic [GW-1:0]   glitch_cnt;
    logic [CW-1:0]   conf_cnt;
    logic            accept, acc_evt;
    logic            conf_now, conf_det, stuck_det, clear_req;
    logic [29:0]     dwell;
    logic [2:0]      tgt;
    logic            known, illegal, bad_order;

    assign pins = {lamp_ped_red, lamp_ped_green, lamp_red, lamp_yellow, lamp_green};

    // Successor of each tracked phase in the normal crossing cycle
    function automatic logic [2:0] next_phase(input logic [2:0] p);
        case (p)
            PH_TEST:      next_phase = PH_GREEN;
            PH_GREEN:     next_phase = PH_YELLOW;
            PH_YELLOW:    next_phase = PH_RED_A;
            PH_RED_A:     next_phase = PH_PED_GREEN;
            PH_PED_GREEN: next_phase = PH_RED_B;
            PH_RED_B:     next_phase = PH_GREEN;
            default:      next_phase = PH_NONE;
        endcase
    endfunction

    // Two-flop synchroniser on the asynchronous lamp lines
    always_ff @(posedge pin3_clk_16mhz) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    // A candidate becomes accepted once seen GLITCH_CYCLES samples in a row;
    // only a change of the accepted pattern raises acc_evt.
    assign accept = (glitch_cnt == GW'(GLITCH_CYCLES)) && (cand != acc_pat);

    // Debounce counter and accepted pattern register
    always_ff @(posedge pin3_clk_16mhz) begin
        if (reset) begin
            cand       <= '0;
            glitch_cnt <= '0;
            acc_pat    <= '0;
            acc_evt    <= 1'b0;
        end else begin
            acc_evt <= accept;
            if (accept)
                acc_pat <= cand;
            if (sync2 != cand) begin
                cand       <= sync2;
                glitch_cnt <= GW'(1);
            end else if (glitch_cnt != GW'(GLITCH_CYCLES)) begin
                glitch_cnt <= glitch_cnt + GW'(1);
            end
        end
    end

    // Walk signal together with a road go signal; the all-on lamp test is exempt
    assign conf_now = sync2[3] & (sync2[0] | sync2[1]) & (sync2 != PAT_TEST);
    assign conf_det = conf_now && (conf_cnt >= CW'(CONFLICT_CYCLES - 1));

    // Count consecutive conflict samples (undebounced path)
    always_ff @(posedge pin3_clk_16mhz) begin
        if (reset || !conf_now)
            conf_cnt <= '0;
        else if (conf_cnt != CW'(CONFLICT_CYCLES))
            conf_cnt <= conf_cnt + CW'(1);
    end

    assign clear_req = (state == ST_FAULT) && fault_clear;
    assign stuck_det = (dwell >= STUCK_LIMIT);

    // Dwell timer since the last accepted change, saturating
    always_ff @(posedge pin3_clk_16mhz) begin
        if (reset || acc_evt || clear_req)
            dwell <= '0;
        else if (dwell != DWELL_MAX)
            dwell <= dwell + 30'd1;
    end

    // Next state: acceptance rules, fault priority and operator clear
    always_comb begin
        state_d   = state;
        code_d    = fault_code;
        phase_d   = phase;
        tgt       = PH_NONE;
        known     = 1'b1;
        illegal   = 1'b0;
        bad_order = 1'b0;

        case (acc_pat)
            PAT_TEST:   tgt = PH_TEST;
            PAT_GREEN:  tgt = PH_GREEN;
            PAT_YELLOW: tgt = PH_YELLOW;
            PAT_PED:    tgt = PH_PED_GREEN;
            // Red is shared by two phases; which one depends on where we came from
            PAT_RED:    tgt = (phase == PH_YELLOW)    ? PH_RED_A :
                              (phase == PH_PED_GREEN) ? PH_RED_B : PH_NONE;
            default:    known = 1'b0;
        endcase

        case (state)
            ST_INIT: begin
                // All-off and red are tolerated while waiting to lock on
                if (acc_evt && acc_pat != PAT_OFF && acc_pat != PAT_RED) begin
                    if (known) begin
                        state_d = ST_RUN;
                        phase_d = tgt;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (acc_evt) begin
                    if (!known)
                        illegal = 1'b1;
                    else if (tgt != next_phase(phase))
                        bad_order = 1'b1;
                    else
                        phase_d = tgt;
                end
            end
            default: ;
        endcase

        if (state == ST_FAULT) begin
            if (fault_clear) begin
                state_d = ST_INIT;
                code_d  = CODE_NONE;
            end
        end else if (conf_det || illegal || bad_order || stuck_det) begin
            state_d = ST_FAULT;
            phase_d = phase;
            code_d  = conf_det  ? CODE_CONFLICT :
                      illegal   ? CODE_ILLEGAL  :
                      bad_order ? CODE_ORDER    : CODE_STUCK;
        end
    end

    // State and registered outputs
    always_ff @(posedge pin3_clk_16mhz) begin
        if (reset) begin
            state         <= ST_INIT;
            fault         <= 1'b0;
            fault_code    <= CODE_NONE;
            safe_override <= 1'b0;
            in_sync       <= 1'b0;
            phase         <= PH_NONE;
        end else begin
            state         <= state_d;
            fault         <= (state_d == ST_FAULT);
            fault_code    <= code_d;
            safe_override <= (state_d == ST_FAULT);
            in_sync       <= (state_d == ST_RUN);
            phase         <= phase_d;
        end
    end

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Bench for lamp_conflict_monitor: directed scenarios followed by a random
// walk of held patterns and short glitches, checked against a pattern-level model.
module tb_lamp_conflict_monitor;

    logic       clk = 1'b0;
    logic       reset, fault_clear;
    logic       lamp_green, lamp_yellow, lamp_red, lamp_ped_green, lamp_ped_red;
    logic       fault, safe_override, in_sync;
    logic [2:0] fault_code, phase;

    int checks   = 0;
    int failures = 0;

    // model: mode 0 INIT, 1 RUN, 2 FAULT
    int         m_mode, m_phase, m_code;
    logic [4:0] held;

    localparam logic [4:0] P_OFF = 5'h00, P_TEST = 5'h1F, P_GRN = 5'h11,
                           P_YEL = 5'h12, P_RED = 5'h14, P_PED = 5'h0C, P_CONF = 5'h19;

    lamp_conflict_monitor #(
        .TIMER_SCALE(10), .GLITCH_CYCLES(4), .CONFLICT_CYCLES(2), .STUCK_SECONDS(20)
    ) dut (
        .pin3_clk_16mhz(clk), .reset(reset),
        .lamp_green(lamp_green), .lamp_yellow(lamp_yellow), .lamp_red(lamp_red),
        .lamp_ped_green(lamp_ped_green), .lamp_ped_red(lamp_ped_red),
        .fault_clear(fault_clear), .fault(fault), .fault_code(fault_code),
        .safe_override(safe_override), .in_sync(in_sync), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pat(input logic [4:0] p);
        {lamp_ped_red, lamp_ped_green, lamp_red, lamp_yellow, lamp_green} = p;
        held = p;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int f, input int c, input int s, input int ph);
        chk({tag, ".fault"},    8'(fault),         8'(f));
        chk({tag, ".code"},     8'(fault_code),    8'(c));
        chk({tag, ".override"}, 8'(safe_override), 8'(f));
        chk({tag, ".in_sync"},  8'(in_sync),       8'(s));
        chk({tag, ".phase"},    8'(phase),         8'(ph));
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, (m_mode == 2) ? 1 : 0, m_code, (m_mode == 1) ? 1 : 0, m_phase);
    endtask

    // Walking pedestrians while road traffic may move; lamp test excluded
    function automatic bit is_conflict(input logic [4:0] p);
        return p[3] && (p[0] || p[1]) && (p != P_TEST);
    endfunction

    // Phase that a legal pattern names; red is resolved by the caller
    function automatic int pat_phase(input logic [4:0] p);
        case (p)
            P_TEST: return 1;
            P_GRN:  return 2;
            P_YEL:  return 3;
            P_PED:  return 5;
            P_RED:  return 7;
            default: return -1;
        endcase
    endfunction

    task automatic m_fault(input int c);
        m_mode = 2;
        m_code = c;
    endtask

    // Effect of a stable new pattern on the model
    task automatic model_hold(input logic [4:0] p);
        int ph;
        int succ [7] = '{0, 2, 3, 4, 5, 6, 2};
        if (m_mode == 2) return;
        if (is_conflict(p)) begin m_fault(2); return; end
        ph = pat_phase(p);
        if (m_mode == 0) begin
            if (p == P_OFF || p == P_RED) return;
            if (ph < 0) m_fault(1);
            else begin m_mode = 1; m_phase = ph; end
        end else begin
            if (ph < 0) m_fault(1);
            else begin
                if (ph == 7) ph = (m_phase == 3) ? 4 : (m_phase == 5) ? 6 : 0;
                if (ph != 0 && succ[m_phase] == ph) m_phase = ph;
                else m_fault(4);
            end
        end
    endtask

    function automatic logic [4:0] pick_pattern();
        logic [4:0] legal [5] = '{P_TEST, P_GRN, P_YEL, P_RED, P_PED};
        int r = $urandom_range(0, 9);
        if (r <= 4 && m_mode == 1) begin
            case (m_phase)
                1, 6:    return P_GRN;
                2:       return P_YEL;
                3, 5:    return P_RED;
                default: return P_PED;
            endcase
        end
        if (r <= 6) return legal[$urandom_range(0, 4)];
        if (r == 7) return P_OFF;
        if (r == 8) return P_CONF;
        return 5'($urandom);
    endfunction

    initial begin
        logic [4:0] seq   [8] = '{P_OFF, P_TEST, P_GRN, P_YEL, P_RED, P_PED, P_RED, P_GRN};
        int         seqph [8] = '{0, 1, 2, 3, 4, 5, 6, 2};
        logic [4:0] p, g;
        int         len;
        bit         force_long = 0;

        reset = 1'b1;
        fault_clear = 1'b0;
        set_pat(P_OFF);
        step(3);
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // normal cycle
        foreach (seq[i]) begin
            set_pat(seq[i]);
            step(50);
            chk_all($sformatf("normal%0d", i), 0, 0, (i > 0) ? 1 : 0, seqph[i]);
        end

        // one-cycle conflict ignored, two-cycle conflict latches code 2
        set_pat(P_CONF); step(1); set_pat(P_GRN); step(10);
        chk_all("conf_pulse1", 0, 0, 1, 2);
        set_pat(P_CONF); step(2); set_pat(P_GRN); step(5);
        chk_all("conf_pulse2", 1, 2, 0, 2);

        // clear returns to INIT
        fault_clear = 1'b1; step(1); fault_clear = 1'b0;
        chk_all("clear1", 0, 0, 0, 2);

        // bad order: green then red, later illegal keeps first code
        set_pat(P_TEST); step(20);
        set_pat(P_GRN);  step(20);
        chk_all("order_green", 0, 0, 1, 2);
        set_pat(P_RED);  step(20);
        chk_all("order_bad", 1, 4, 0, 2);
        set_pat(5'h08);  step(20);
        chk_all("order_keep", 1, 4, 0, 2);

        // clear, red stays in INIT, ped green locks on
        fault_clear = 1'b1; step(1); fault_clear = 1'b0;
        chk_all("clear2", 0, 0, 0, 2);
        set_pat(P_RED); step(20);
        chk_all("init_red", 0, 0, 0, 2);
        set_pat(P_PED); step(20);
        chk_all("init_ped", 0, 0, 1, 5);

        // stuck: change before the dwell limit, then hold past it
        set_pat(P_RED); step(20);
        set_pat(P_GRN); step(190);
        chk_all("dwell_190", 0, 0, 1, 2);
        set_pat(P_YEL); step(200);
        chk_all("dwell_200", 0, 0, 1, 3);
        step(15);
        chk_all("stuck", 1, 3, 0, 3);

        // reset mid-fault and mid-debounce
        reset = 1'b1; step(1); reset = 1'b0;
        chk_all("rst_fault", 0, 0, 0, 0);
        set_pat(P_PED); step(3);
        reset = 1'b1; set_pat(P_OFF); step(1); reset = 1'b0;
        chk_all("rst_deb", 0, 0, 0, 0);
        step(12);
        chk_all("rst_idle", 0, 0, 0, 0);
        set_pat(P_GRN); step(20);
        set_pat(5'h06); step(3); set_pat(P_GRN); step(12);
        chk_all("glitch3", 0, 0, 1, 2);

        // random walk against the model
        m_mode = 1; m_phase = 2; m_code = 0;
        for (int seg = 0; seg < 150; seg++) begin
            if (!force_long && $urandom_range(0, 4) == 0) begin
                p   = held;
                g   = ($urandom_range(0, 1) == 1) ? P_CONF : 5'($urandom);
                len = $urandom_range(1, 3);
                set_pat(g); step(len); set_pat(p); step(12);
                if (g != p && is_conflict(g) && len >= 2 && m_mode != 2) m_fault(2);
                force_long = 1;
            end else begin
                p = pick_pattern();
                while (p == held) p = 5'($urandom);
                set_pat(p);
                step($urandom_range(12, 60));
                model_hold(p);
                force_long = 0;
            end
            chk_model($sformatf("rand%0d", seg));
            if (m_mode == 2 && !is_conflict(held) && $urandom_range(0, 1) == 1) begin
                fault_clear = 1'b1; step(1); fault_clear = 1'b0;
                m_mode = 0; m_code = 0;
                chk_model($sformatf("rclr%0d", seg));
            end else if (m_mode != 2 && $urandom_range(0, 9) == 0) begin
                fault_clear = 1'b1; step(1); fault_clear = 1'b0;
                chk_model($sformatf("rnoclr%0d", seg));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
